neosd_card_cmd: RTL and testbench
=================================

Name: neosd_card_cmd

Overview:
- Card-side counterpart of the neosd host controller's command path: an SD CMD-line responder that makes an FPGA behave as the card end of the 1-bit SD bus.
- Samples the host's SD clock and CMD line in the clk_i domain and deframes 48-bit commands, checking framing and CRC7.
- Hands each valid command to local card logic through a valid/ready handshake, then serialises a 48-bit response on CMD after a programmable Ncr delay.
- Used as a loopback partner for neosd in benches and FPGA self-test builds.

Parameters:
- NCR, 2, SD clock cycles between the command end bit and the response start bit (legal 2..64).
- SYNC_STAGES, 2, synchroniser depth for sd_clk_i and sd_cmd_i.

Ports:
- clk_i  in  1  system clock; must be at least 4x the SD clock frequency.
- rstn_i  in  1  reset, asynchronous, active-low.
- sd_clk_i  in  1  SD clock from the host (asynchronous to clk_i).
- sd_cmd_i  in  1  CMD line input.
- sd_cmd_o  out  1  CMD line output.
- sd_cmd_oe  out  1  CMD output enable, 1 = drive.
- cmd_valid_o  out  1  received command available.
- cmd_idx_o  out  6  command index.
- cmd_arg_o  out  32  command argument.
- cmd_err_o  out  1  one-cycle pulse on a rejected frame.
- rsp_valid_i  in  1  response supplied by card logic.
- rsp_ready_o  out  1  responder accepts a response.
- rsp_none_i  in  1  with rsp_valid_i: send no response.
- rsp_idx_i  in  6  response index field.
- rsp_arg_i  in  32  response payload (card status or argument).

Behaviour:
- Reset values: sd_cmd_o=1, sd_cmd_oe=0, cmd_valid_o=0, cmd_idx_o=0, cmd_arg_o=0, cmd_err_o=0, rsp_ready_o=0; FSM in IDLE. Asserting reset mid-frame aborts immediately and releases CMD.
- Edge detection: sd_clk_i and sd_cmd_i pass through the SYNC_STAGES synchroniser. One extra flop on the synchronised clock gives a rise pulse and a fall pulse, each one clk_i cycle wide. All bus activity advances only on these pulses; if the SD clock stops, the FSM holds state.
- IDLE: on a rise pulse with CMD=0, load the start bit, clear the CRC, set bitcount=1 and go to RX.
- RX: on each rise pulse, shift in CMD and increment bitcount. Bits 1..39 feed the CRC. After bit 47 (48 bits total), go to CHECK.
- CHECK: takes one clk_i cycle. The frame is valid only if the transmission bit=1, the end bit=1 and the received CRC7 equals the computed CRC7.
  - Valid: latch cmd_idx_o and cmd_arg_o, set cmd_valid_o=1, clear the Ncr counter, go to WAIT.
  - Invalid: pulse cmd_err_o and go to IDLE. No response is sent, matching the card's silent rejection of bad commands.
- WAIT: rsp_ready_o=1, and the counter increments on each rise pulse (saturating at NCR).
  - Handshake on rsp_valid_i & rsp_ready_o: drop cmd_valid_o and rsp_ready_o.
  - If rsp_none_i=1, go to IDLE.
  - Otherwise latch the response frame {0,0,rsp_idx_i,rsp_arg_i} and go to TXW.
- rsp_valid_i outside WAIT is ignored; rsp_ready_o is 0 there.
- TXW: wait until the counter is at least NCR, then take the next fall pulse. On that pulse set sd_cmd_oe=1, drive the start bit and go to TX. If the handshake completes after NCR has elapsed, the response starts on the first fall pulse after the handshake.
- TX: on each fall pulse, drive the next bit, MSB first. The CRC covers bits 0..39; CRC7 is shifted out in bits 40..46, then end bit 1. On the fall pulse after the end bit, set sd_cmd_oe=0, sd_cmd_o=1 and go to IDLE.
- A new start bit arriving during WAIT, TXW or TX is ignored; the bus is half-duplex.
- CRC7: polynomial x^7+x^3+1, initial value 0, one update per bit-enable.

Decomposition:
- Package neosd_card_pkg holds: state enumeration (IDLE, RX, CHECK, WAIT, TXW, TX), FRAME_BITS=48, bit-position constants (start, transmission, index, argument, CRC, end), CRC7_POLY=7'h09.
- One sub-module, neosd_crc7: serial CRC7 with clear, enable and data input and a 7-bit output. Instantiated once and shared between RX and TX, since they never overlap.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 at SD clock = clk_i/8 -> cmd_valid_o=1, idx=0, arg=0. Respond with rsp_none_i=1 -> CMD never driven, FSM returns to IDLE.
- CMD8 frame 48 00 00 01 AA 87 -> idx=8, arg=0x000001AA. Respond idx=8, arg=0x000001AA -> 48-bit frame on CMD with leading bits 0,0, CRC matching the package CRC model, end bit 1. Start bit appears exactly NCR=2 SD clocks after the command end bit.
- CMD55 frame 77 00 00 00 00 65 with one argument bit flipped -> cmd_err_o pulses once, cmd_valid_o stays 0, sd_cmd_oe stays 0.
- Frame with end bit 0 or transmission bit 0 -> cmd_err_o pulses, no response.
- Response handshake delayed 20 SD clocks, with NCR=8 -> response starts on the first SD falling edge after the handshake. With an immediate handshake -> start bit lands exactly 8 clocks after the end bit.
- rstn_i asserted during bit 20 of TX -> sd_cmd_oe=0 and sd_cmd_o=1 immediately. After release, a fresh CMD0 is decoded correctly.

Source files
------------

// File: rtl/neosd_card_pkg.sv
// Shared types and constants for the neosd card-side CMD responder.
package neosd_card_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      CHECK,
      WAIT,
      TXW,
      TX
   } state_t;

   localparam int unsigned FRAME_BITS = 48;

   // Field positions in wire order (0 = first bit on the line).
   localparam int unsigned POS_START = 0;
   localparam int unsigned POS_TRANS = 1;
   localparam int unsigned POS_IDX   = 2;
   localparam int unsigned POS_ARG   = 8;
   localparam int unsigned POS_CRC   = 40;
   localparam int unsigned POS_END   = 47;

   localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) with synchronous clear and bit enable.
module neosd_crc7
   import neosd_card_pkg::*;
(
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       din_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q;
   logic       fb;

   assign fb    = din_i ^ crc_q[6];
   assign crc_o = crc_q;

   // LFSR update, clear takes priority over a data bit
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         crc_q <= '0;
      end else if (clr_i) begin
         crc_q <= '0;
      end else if (en_i) begin
         crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

endmodule

// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD-line responder: deframes host commands, hands them to
// local card logic and serialises the response after an Ncr gap.
module neosd_card_cmd
   import neosd_card_pkg::*;
#(
   parameter int unsigned NCR         = 2,
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        sd_clk_i,
   input  logic        sd_cmd_i,
   output logic        sd_cmd_o,
   output logic        sd_cmd_oe,
   output logic        cmd_valid_o,
   output logic [5:0]  cmd_idx_o,
   output logic [31:0] cmd_arg_o,
   output logic        cmd_err_o,
   input  logic        rsp_valid_i,
   output logic        rsp_ready_o,
   input  logic        rsp_none_i,
   input  logic [5:0]  rsp_idx_i,
   input  logic [31:0] rsp_arg_i
);

   localparam int unsigned TOP    = FRAME_BITS - 1;
   localparam logic [6:0]  NCR_MX = 7'(NCR);
   localparam logic [5:0]  B_CRC  = 6'(POS_CRC);
   localparam logic [5:0]  B_END  = 6'(POS_END);

   state_t             state, state_nx;
   logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
   logic               clk_d, clk_s, cmd_s, clk_rise, clk_fall;
   logic [TOP:0]       rx_sr;
   logic [39:0]        tx_sr;
   logic [5:0]         bit_cnt;
   logic [6:0]         ncr_cnt;
   logic               ncr_done, frame_ok;
   logic               crc_clr, crc_en, crc_din;
   logic [6:0]         crc_q;

   assign clk_s       = clk_sync[SYNC_STAGES-1];
   assign cmd_s       = cmd_sync[SYNC_STAGES-1];
   assign clk_rise    = clk_s & ~clk_d;
   assign clk_fall    = ~clk_s & clk_d;
   assign ncr_done    = (ncr_cnt >= NCR_MX);
   assign rsp_ready_o = (state == WAIT);
   assign frame_ok    = ~rx_sr[TOP-POS_START] & rx_sr[TOP-POS_TRANS] &
                        rx_sr[TOP-POS_END] & (rx_sr[TOP-POS_CRC -: 7] == crc_q);

   // Synchronise the host clock and CMD line; one extra flop for edge pulses
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         clk_sync <= '0;
         cmd_sync <= '1;
         clk_d    <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk_i};
         cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], sd_cmd_i};
         clk_d    <= clk_s;
      end
   end

   neosd_crc7 u_crc (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (crc_clr),
      .en_i   (crc_en),
      .din_i  (crc_din),
      .crc_o  (crc_q)
   );

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state logic and CRC steering (RX and TX share one CRC engine)
   always_comb begin
      state_nx = state;
      crc_clr  = 1'b0;
      crc_en   = 1'b0;
      crc_din  = cmd_s;
      case (state)
         IDLE: begin
            if (clk_rise && !cmd_s) begin
               crc_clr  = 1'b1;
               state_nx = RX;
            end
         end
         RX: begin
            if (clk_rise) begin
               crc_en = (bit_cnt < B_CRC);
               if (bit_cnt == B_END) state_nx = CHECK;
            end
         end
         CHECK: state_nx = frame_ok ? WAIT : IDLE;
         WAIT: begin
            if (rsp_valid_i) begin
               crc_clr  = 1'b1;
               state_nx = rsp_none_i ? IDLE : TXW;
            end
         end
         TXW: begin
            crc_din = tx_sr[39];
            if (clk_fall && ncr_done) begin
               crc_en   = 1'b1;
               state_nx = TX;
            end
         end
         TX: begin
            crc_din = tx_sr[39];
            if (clk_fall) begin
               crc_en = (bit_cnt < B_CRC);
               if (bit_cnt == 6'(FRAME_BITS)) state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Frame shifting, Ncr counting, handshake flags and CMD line drive
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rx_sr       <= '0;
         tx_sr       <= '0;
         bit_cnt     <= '0;
         ncr_cnt     <= '0;
         sd_cmd_o    <= 1'b1;
         sd_cmd_oe   <= 1'b0;
         cmd_valid_o <= 1'b0;
         cmd_idx_o   <= '0;
         cmd_arg_o   <= '0;
         cmd_err_o   <= 1'b0;
      end else begin
         cmd_err_o <= 1'b0;
         if ((state == WAIT || state == TXW) && clk_rise && !ncr_done)
            ncr_cnt <= ncr_cnt + 7'd1;
         case (state)
            IDLE: begin
               if (clk_rise && !cmd_s) begin
                  rx_sr   <= '0;
                  bit_cnt <= 6'd1;
               end
            end
            RX: begin
               if (clk_rise) begin
                  rx_sr   <= {rx_sr[TOP-1:0], cmd_s};
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            CHECK: begin
               if (frame_ok) begin
                  cmd_idx_o   <= rx_sr[TOP-POS_IDX -: 6];
                  cmd_arg_o   <= rx_sr[TOP-POS_ARG -: 32];
                  cmd_valid_o <= 1'b1;
                  ncr_cnt     <= '0;
               end else begin
                  cmd_err_o <= 1'b1;
               end
            end
            WAIT: begin
               if (rsp_valid_i) begin
                  cmd_valid_o <= 1'b0;
                  if (!rsp_none_i) tx_sr <= {2'b00, rsp_idx_i, rsp_arg_i};
               end
            end
            TXW: begin
               if (clk_fall && ncr_done) begin
                  sd_cmd_oe <= 1'b1;
                  sd_cmd_o  <= tx_sr[39];
                  tx_sr     <= {tx_sr[38:0], 1'b0};
                  bit_cnt   <= 6'd1;
               end
            end
            TX: begin
               if (clk_fall) begin
                  bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt < B_CRC) begin
                     sd_cmd_o <= tx_sr[39];
                     tx_sr    <= {tx_sr[38:0], 1'b0};
                  end else if (bit_cnt < B_END) begin
                     // CRC is final once bit 39 was absorbed; send MSB first
                     sd_cmd_o <= crc_q[3'(B_END - 6'd1 - bit_cnt)];
                  end else if (bit_cnt == B_END) begin
                     sd_cmd_o <= 1'b1;
                  end else begin
                     sd_cmd_o  <= 1'b1;
                     sd_cmd_oe <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Bench for neosd_card_cmd: acts as the SD host, with two responders
// (NCR=2 and NCR=8) sharing the bus inputs.
module tb_neosd_card_cmd;

   logic clk = 1'b0, rstn = 1'b0, sd_clk = 1'b0, sd_cmd = 1'b1;
   logic [5:0]  rsp_idx = '0;
   logic [31:0] rsp_arg = '0;

   logic cmd_o_a, oe_a, valid_a, err_a, ready_a, rsp_valid_a = 1'b1, rsp_none_a = 1'b1;
   logic cmd_o_b, oe_b, valid_b, err_b, ready_b, rsp_valid_b = 1'b1, rsp_none_b = 1'b1;
   logic [5:0]  idx_a, idx_b;
   logic [31:0] arg_a, arg_b;

   int n_chk = 0, n_pass = 0;
   int rise_cnt = 0;
   int vcnt_a = 0, ecnt_a = 0, ocnt_a = 0, vcnt_b = 0, ecnt_b = 0, ocnt_b = 0;
   logic vq_a = 1'b0, vq_b = 1'b0;
   int end_rise;

   always #5  clk    = ~clk;
   always #40 sd_clk = ~sd_clk;

   neosd_card_cmd #(.NCR(2), .SYNC_STAGES(2)) dut_a (
      .clk_i(clk), .rstn_i(rstn), .sd_clk_i(sd_clk), .sd_cmd_i(sd_cmd),
      .sd_cmd_o(cmd_o_a), .sd_cmd_oe(oe_a), .cmd_valid_o(valid_a),
      .cmd_idx_o(idx_a), .cmd_arg_o(arg_a), .cmd_err_o(err_a),
      .rsp_valid_i(rsp_valid_a), .rsp_ready_o(ready_a), .rsp_none_i(rsp_none_a),
      .rsp_idx_i(rsp_idx), .rsp_arg_i(rsp_arg));

   neosd_card_cmd #(.NCR(8), .SYNC_STAGES(2)) dut_b (
      .clk_i(clk), .rstn_i(rstn), .sd_clk_i(sd_clk), .sd_cmd_i(sd_cmd),
      .sd_cmd_o(cmd_o_b), .sd_cmd_oe(oe_b), .cmd_valid_o(valid_b),
      .cmd_idx_o(idx_b), .cmd_arg_o(arg_b), .cmd_err_o(err_b),
      .rsp_valid_i(rsp_valid_b), .rsp_ready_o(ready_b), .rsp_none_i(rsp_none_b),
      .rsp_idx_i(rsp_idx), .rsp_arg_i(rsp_arg));

   always @(posedge sd_clk) rise_cnt <= rise_cnt + 1;

   // Event counters: valid rising edges, error-pulse cycles, driven cycles
   always @(negedge clk) begin
      vq_a <= valid_a;
      vq_b <= valid_b;
      if (valid_a && !vq_a) vcnt_a <= vcnt_a + 1;
      if (valid_b && !vq_b) vcnt_b <= vcnt_b + 1;
      if (err_a) ecnt_a <= ecnt_a + 1;
      if (err_b) ecnt_b <= ecnt_b + 1;
      if (oe_a)  ocnt_a <= ocnt_a + 1;
      if (oe_b)  ocnt_b <= ocnt_b + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Reference CRC7 by polynomial long division of M(x)*x^7 by x^7+x^3+1
   function automatic logic [6:0] crc7_ref(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] mk_frame(input logic [1:0] hdr, input logic [5:0] idx,
                                            input logic [31:0] arg);
      return {hdr, idx, arg, crc7_ref({hdr, idx, arg}), 1'b1};
   endfunction

   function automatic logic oe_of(input bit sel);
      return sel ? oe_b : oe_a;
   endfunction

   function automatic logic cmdo_of(input bit sel);
      return sel ? cmd_o_b : cmd_o_a;
   endfunction

   task automatic send_frame(input logic [47:0] f);
      for (int i = 0; i < 48; i++) begin
         @(negedge sd_clk);
         sd_cmd = f[47-i];
      end
      @(posedge sd_clk); #1;
      end_rise = rise_cnt;
      @(negedge sd_clk);
      sd_cmd = 1'b1;
   endtask

   task automatic wait_start(input bit sel, output bit found, output int srise);
      found = 1'b0;
      srise = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge sd_clk); #1;
         if (oe_of(sel) && !cmdo_of(sel)) begin
            found = 1'b1;
            srise = rise_cnt;
         end
      end
      if (!found) chk("start_timeout", 64'(0), 64'(1));
   endtask

   task automatic capture_rest(input bit sel, output logic [47:0] f);
      f = '0;
      for (int i = 1; i < 48; i++) begin
         @(posedge sd_clk); #1;
         f[47-i] = cmdo_of(sel);
      end
   endtask

   task automatic idle_sd(input int n);
      repeat (n) @(posedge sd_clk);
      #1;
   endtask

   typedef struct {
      logic [47:0] frame;
      logic        ok;
      logic [5:0]  idx;
      logic [31:0] arg;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int v0, e0, o0, vb0, srise, hs, flip;
      bit found, sel, none, exp_ok;
      logic [47:0] f, rf, exp_f;
      logic [5:0] ridx;
      logic [31:0] rarg;

      vecs[0] = '{48'h40_0000_0000_95, 1'b1, 6'd0,  32'h0000_0000};
      vecs[1] = '{48'h48_0000_01AA_87, 1'b1, 6'd8,  32'h0000_01AA};
      vecs[2] = '{48'h77_0000_0000_65, 1'b1, 6'd55, 32'h0000_0000};
      vecs[3] = '{48'h77_0000_0100_65, 1'b0, 6'd0,  32'h0};
      vecs[4] = '{48'h40_0000_0000_94, 1'b0, 6'd0,  32'h0};
      vecs[5] = '{48'h00_0000_0000_95, 1'b0, 6'd0,  32'h0};

      // Reset state
      #33;
      chk("rst_cmd_o", 64'(cmd_o_a), 64'(1));
      chk("rst_oe", 64'(oe_a), 64'(0));
      chk("rst_valid", 64'(valid_a), 64'(0));
      chk("rst_idx", 64'(idx_a), 64'(0));
      chk("rst_arg", 64'(arg_a), 64'(0));
      chk("rst_err", 64'(err_a), 64'(0));
      chk("rst_ready", 64'(ready_a), 64'(0));
      chk("rst_oe_b", 64'(oe_b), 64'(0));
      #70 rstn = 1'b1;
      idle_sd(4);

      // Table: decode / reject with silent card logic on both responders
      for (int t = 0; t < 6; t++) begin
         v0 = vcnt_a; e0 = ecnt_a; o0 = ocnt_a; vb0 = vcnt_b;
         send_frame(vecs[t].frame);
         idle_sd(4);
         chk($sformatf("tab%0d_valid", t), 64'(vcnt_a - v0), 64'(vecs[t].ok));
         chk($sformatf("tab%0d_err", t), 64'(ecnt_a - e0), 64'(!vecs[t].ok));
         chk($sformatf("tab%0d_noe", t), 64'(ocnt_a - o0), 64'(0));
         chk($sformatf("tab%0d_valid_b", t), 64'(vcnt_b - vb0), 64'(vecs[t].ok));
         if (vecs[t].ok) begin
            chk($sformatf("tab%0d_idx", t), 64'(idx_a), 64'(vecs[t].idx));
            chk($sformatf("tab%0d_arg", t), 64'(arg_a), 64'(vecs[t].arg));
         end
      end

      // CMD8 with a real response on the NCR=2 responder
      rsp_idx = 6'd8; rsp_arg = 32'h0000_01AA;
      rsp_none_a = 1'b0;
      send_frame(48'h48_0000_01AA_87);
      wait_start(1'b0, found, srise);
      chk("cmd8_gap", 64'(srise - end_rise - 1), 64'(2));
      capture_rest(1'b0, rf);
      chk("cmd8_rsp", rf, {16'h0, mk_frame(2'b00, 6'd8, 32'h1AA)});
      idle_sd(2);
      chk("cmd8_release_oe", 64'(oe_a), 64'(0));
      chk("cmd8_release_cmd", 64'(cmd_o_a), 64'(1));
      rsp_none_a = 1'b1;

      // NCR=8, immediate handshake
      rsp_none_b = 1'b0; rsp_idx = 6'd17; rsp_arg = 32'hDEAD_BEEF;
      send_frame(mk_frame(2'b01, 6'd17, 32'h0000_0200));
      wait_start(1'b1, found, srise);
      chk("ncr8_gap", 64'(srise - end_rise - 1), 64'(8));
      capture_rest(1'b1, rf);
      chk("ncr8_rsp", rf, {16'h0, mk_frame(2'b00, 6'd17, 32'hDEAD_BEEF)});
      idle_sd(3);

      // NCR=8, handshake delayed by 20 SD clocks
      rsp_valid_b = 1'b0;
      o0 = ocnt_b;
      send_frame(mk_frame(2'b01, 6'd13, 32'h1234_0000));
      repeat (20) @(posedge sd_clk);
      #1;
      chk("dly_valid_held", 64'(valid_b), 64'(1));
      chk("dly_ready", 64'(ready_b), 64'(1));
      chk("dly_no_drive", 64'(ocnt_b - o0), 64'(0));
      hs = rise_cnt;
      rsp_valid_b = 1'b1;
      #30;
      chk("dly_valid_drop", 64'(valid_b), 64'(0));
      chk("dly_ready_drop", 64'(ready_b), 64'(0));
      wait_start(1'b1, found, srise);
      chk("dly_start", 64'(srise), 64'(hs + 1));
      capture_rest(1'b1, rf);
      chk("dly_rsp", rf, {16'h0, mk_frame(2'b00, 6'd17, 32'hDEAD_BEEF)});
      idle_sd(3);
      rsp_none_b = 1'b1;

      // Reset during bit 20 of a response, then a fresh CMD0
      rsp_none_a = 1'b0;
      send_frame(48'h48_0000_01AA_87);
      wait_start(1'b0, found, srise);
      repeat (20) @(posedge sd_clk);
      #20 rstn = 1'b0;
      #1;
      chk("rst_mid_oe", 64'(oe_a), 64'(0));
      chk("rst_mid_cmd", 64'(cmd_o_a), 64'(1));
      #50 rstn = 1'b1;
      rsp_none_a = 1'b1;
      idle_sd(4);
      v0 = vcnt_a; e0 = ecnt_a;
      send_frame(48'h40_0000_0000_95);
      idle_sd(4);
      chk("post_rst_valid", 64'(vcnt_a - v0), 64'(1));
      chk("post_rst_err", 64'(ecnt_a - e0), 64'(0));
      chk("post_rst_idx", 64'(idx_a), 64'(0));

      // Randomised commands against the reference model
      for (int n = 0; n < 10; n++) begin
         sel  = 1'($urandom_range(0, 1));
         none = ($urandom_range(0, 3) == 0);
         f = mk_frame(2'b01, 6'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            flip = 47 - int'($urandom_range(1, 47));
            f[flip] = ~f[flip];
         end
         ridx = 6'($urandom); rarg = $urandom;
         rsp_idx = ridx; rsp_arg = rarg;
         exp_ok = f[46] && f[0] && (f[7:1] == crc7_ref(f[47:8]));
         rsp_none_a = sel ? 1'b1 : none;
         rsp_none_b = sel ? none : 1'b1;
         v0 = sel ? vcnt_b : vcnt_a;
         e0 = sel ? ecnt_b : ecnt_a;
         o0 = sel ? ocnt_b : ocnt_a;
         send_frame(f);
         if (exp_ok && !none) begin
            wait_start(sel, found, srise);
            chk($sformatf("rnd%0d_gap", n), 64'(srise - end_rise - 1), 64'(sel ? 8 : 2));
            capture_rest(sel, rf);
            exp_f = mk_frame(2'b00, ridx, rarg);
            chk($sformatf("rnd%0d_rsp", n), 64'(rf), 64'(exp_f));
            idle_sd(3);
         end else begin
            idle_sd(12);
            chk($sformatf("rnd%0d_silent", n), 64'((sel ? ocnt_b : ocnt_a) - o0), 64'(0));
         end
         chk($sformatf("rnd%0d_valid", n), 64'((sel ? vcnt_b : vcnt_a) - v0), 64'(exp_ok));
         chk($sformatf("rnd%0d_err", n), 64'((sel ? ecnt_b : ecnt_a) - e0), 64'(!exp_ok));
         if (exp_ok) begin
            chk($sformatf("rnd%0d_idx", n), 64'(sel ? idx_b : idx_a), 64'(f[45:40]));
            chk($sformatf("rnd%0d_arg", n), 64'(sel ? arg_b : arg_a), 64'(f[39:8]));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
